// File: rtl/ov7670_stream_pkg.sv
// Shared definitions for the synthetic OV7670 stream generator:
// FSM states, pattern mode codes, colour-bar palette and CRC-16-CCITT helpers.
package ov7670_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VFRONT
    } state_e;

    localparam logic [1:0] MODE_BARS   = 2'd0;
    localparam logic [1:0] MODE_RAMP   = 2'd1;
    localparam logic [1:0] MODE_SOLID  = 2'd2;
    localparam logic [1:0] MODE_SQUARE = 2'd3;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One byte of CRC-16-CCITT, MSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        logic [7:0]  b;
        c = crc;
        b = data;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[15] ^ b[7]) c = {c[14:0], 1'b0} ^ CRC_POLY;
            else              c = {c[14:0], 1'b0};
            b = {b[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/ov7670_stream_pattern.sv
// Combinational test-pattern generator: maps (mode, x, y, square x, solid colour)
// to one RGB565 pixel.
module ov7670_stream_pattern
    import ov7670_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned SQ_SIZE  = 16
) (
    input  logic [1:0]  mode_i,
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic [15:0] sq_x_i,
    input  logic [15:0] solid_i,
    output logic [15:0] pixel_o
);

    localparam logic [15:0] BAR_W = 16'(H_ACTIVE / 8);
    localparam logic [15:0] SQ_W  = 16'(SQ_SIZE);
    localparam logic [15:0] SQ_Y0 = 16'(V_ACTIVE / 2 - SQ_SIZE / 2);

    logic [15:0] bar_idx;
    logic        in_sq;

    // Select the pixel colour for the current mode
    always_comb begin
        bar_idx = x_i / BAR_W;
        in_sq   = (x_i >= sq_x_i) && (x_i < sq_x_i + SQ_W) &&
                  (y_i >= SQ_Y0)  && (y_i < SQ_Y0 + SQ_W);
        pixel_o = '0;
        case (mode_i)
            MODE_BARS: begin
                case (bar_idx)
                    16'd0:   pixel_o = BAR_WHITE;
                    16'd1:   pixel_o = BAR_YELLOW;
                    16'd2:   pixel_o = BAR_CYAN;
                    16'd3:   pixel_o = BAR_GREEN;
                    16'd4:   pixel_o = BAR_MAGENTA;
                    16'd5:   pixel_o = BAR_RED;
                    16'd6:   pixel_o = BAR_BLUE;
                    default: pixel_o = BAR_BLACK;
                endcase
            end
            MODE_RAMP:   pixel_o = {x_i[7:3], x_i[7:2], x_i[7:3]};
            MODE_SOLID:  pixel_o = solid_i;
            MODE_SQUARE: pixel_o = in_sq ? 16'hFFFF : 16'h0000;
            default:     pixel_o = '0;
        endcase
    end

endmodule

// File: rtl/ov7670_stream_gen.sv
// Synthetic OV7670 camera: emits PCLK/VSYNC/HREF/D in RGB565 with selectable
// test patterns. Optional macro STREAM_GEN_CRC_EN adds a per-frame CRC-16-CCITT
// over all HREF bytes; without it frame_crc_o is tied to zero.
module ov7670_stream_gen
    import ov7670_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 320,
    parameter int unsigned V_ACTIVE    = 240,
    parameter int unsigned H_BLANK     = 144,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 17,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned SQ_SIZE     = 16,
    parameter int unsigned SQ_STEP     = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic [1:0]  mode_i,
    input  logic [15:0] solid_rgb_i,
    output logic        pclk_o,
    output logic        vsync_o,
    output logic        href_o,
    output logic [7:0]  d_o,
    output logic        frame_done_o,
    output logic [15:0] frame_count_o,
    output logic [15:0] frame_crc_o
);

    localparam logic [15:0] LINE_LAST = 16'(2 * H_ACTIVE + H_BLANK - 1);
    localparam logic [15:0] ACT_LAST  = 16'(2 * H_ACTIVE - 1);
    localparam logic [15:0] HBL_LAST  = 16'(H_BLANK - 1);
    localparam logic [15:0] VS_LAST   = 16'(VSYNC_LINES - 1);
    localparam logic [15:0] VB_LAST   = 16'(V_BACK - 1);
    localparam logic [15:0] VA_LAST   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] VF_LAST   = 16'(V_FRONT - 1);
    localparam logic [15:0] SQ_STEP_W = 16'(SQ_STEP);
    localparam logic [16:0] SQ_ADV    = 17'(SQ_STEP + SQ_SIZE);
    localparam logic [16:0] H_LIM     = 17'(H_ACTIVE);

    state_e      state_q, state_d;
    logic [15:0] hcnt_q, hcnt_d;       // slot within the current line/segment
    logic [15:0] vcnt_q, vcnt_d;       // line within the current state
    logic        pclk_q;
    logic        vsync_q, href_q, frame_done_q;
    logic [7:0]  d_q;
    logic [15:0] frame_count_q;
    logic [15:0] sq_x_q;
    logic [1:0]  mode_q;
    logic [15:0] solid_q;

    logic        tick;
    logic        enter_vs;
    logic        vsync_slot, href_slot, last_slot;
    logic [7:0]  byte_slot;
    logic [15:0] pixel;

    assign tick     = pclk_q;
    assign enter_vs = (state_d == ST_VSYNC) && (state_q != ST_VSYNC);

    ov7670_stream_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .SQ_SIZE  (SQ_SIZE)
    ) u_pattern (
        .mode_i  (mode_q),
        .x_i     ({1'b0, hcnt_q[15:1]}),
        .y_i     (vcnt_q),
        .sq_x_i  (sq_x_q),
        .solid_i (solid_q),
        .pixel_o (pixel)
    );

    // FSM state and slot/line counters
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
        end
    end

    // Next-state: advance one slot per tick through the frame geometry
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d = ST_VSYNC;
                    hcnt_d  = '0;
                    vcnt_d  = '0;
                end
            end
            ST_VSYNC, ST_VBACK, ST_VFRONT: begin
                if (tick) begin
                    if (hcnt_q != LINE_LAST) begin
                        hcnt_d = hcnt_q + 16'd1;
                    end else begin
                        hcnt_d = '0;
                        vcnt_d = vcnt_q + 16'd1;
                        if (state_q == ST_VSYNC && vcnt_q == VS_LAST) begin
                            state_d = ST_VBACK;
                            vcnt_d  = '0;
                        end else if (state_q == ST_VBACK && vcnt_q == VB_LAST) begin
                            state_d = ST_ACTIVE;
                            vcnt_d  = '0;
                        end else if (state_q == ST_VFRONT && vcnt_q == VF_LAST) begin
                            state_d = en_i ? ST_VSYNC : ST_IDLE;
                            vcnt_d  = '0;
                        end
                    end
                end
            end
            ST_ACTIVE: begin
                if (tick) begin
                    if (hcnt_q == ACT_LAST) begin
                        state_d = ST_HBLANK;
                        hcnt_d  = '0;
                    end else begin
                        hcnt_d = hcnt_q + 16'd1;
                    end
                end
            end
            ST_HBLANK: begin
                if (tick) begin
                    if (hcnt_q == HBL_LAST) begin
                        hcnt_d = '0;
                        if (vcnt_q == VA_LAST) begin
                            state_d = ST_VFRONT;
                            vcnt_d  = '0;
                        end else begin
                            state_d = ST_ACTIVE;
                            vcnt_d  = vcnt_q + 16'd1;
                        end
                    end else begin
                        hcnt_d = hcnt_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the slot described by the current state
    always_comb begin
        vsync_slot = (state_q == ST_VSYNC);
        href_slot  = (state_q == ST_ACTIVE);
        byte_slot  = '0;
        if (href_slot) byte_slot = hcnt_q[0] ? pixel[7:0] : pixel[15:8];
        last_slot  = tick && (state_q == ST_VFRONT) &&
                     (hcnt_q == LINE_LAST) && (vcnt_q == VF_LAST);
    end

    // Emulated PCLK: free-running divide-by-two outside IDLE
    always_ff @(posedge clk_i) begin
        if (reset_i) pclk_q <= 1'b0;
        else         pclk_q <= (state_q == ST_IDLE) ? 1'b0 : ~pclk_q;
    end

    // Bus outputs change only on a slot tick, i.e. as PCLK falls
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            d_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= last_slot;
            if (tick) begin
                vsync_q <= vsync_slot;
                href_q  <= href_slot;
                d_q     <= byte_slot;
            end
        end
    end

    // Per-frame bookkeeping: pattern latch, frame counter, square position
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mode_q        <= MODE_BARS;
            solid_q       <= '0;
            frame_count_q <= '0;
            sq_x_q        <= '0;
        end else begin
            if (enter_vs) begin
                mode_q  <= mode_i;
                solid_q <= solid_rgb_i;
            end
            if (last_slot) begin
                frame_count_q <= frame_count_q + 16'd1;
                if (({1'b0, sq_x_q} + SQ_ADV) > H_LIM) sq_x_q <= '0;
                else                                   sq_x_q <= sq_x_q + SQ_STEP_W;
            end
        end
    end

`ifdef STREAM_GEN_CRC_EN
    logic [15:0] crc_q;
    logic [15:0] frame_crc_q;

    // Running CRC over HREF bytes, published at end of frame
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            crc_q       <= CRC_INIT;
            frame_crc_q <= '0;
        end else begin
            if (enter_vs)                crc_q <= CRC_INIT;
            else if (tick && href_slot)  crc_q <= crc16_byte(crc_q, byte_slot);
            if (last_slot)               frame_crc_q <= crc_q;
        end
    end

    assign frame_crc_o = frame_crc_q;
`else
    assign frame_crc_o = '0;
`endif

    assign pclk_o        = pclk_q;
    assign vsync_o       = vsync_q;
    assign href_o        = href_q;
    assign d_o           = d_q;
    assign frame_done_o  = frame_done_q;
    assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Self-checking bench for ov7670_stream_gen using a slot-arithmetic reference model.
module tb_ov7670_stream_gen;

    localparam int H   = 16;
    localparam int V   = 4;
    localparam int HB  = 4;
    localparam int VS  = 1;
    localparam int VB  = 1;
    localparam int VF  = 1;
    localparam int SQ  = 4;
    localparam int STP = 2;
    localparam int LINE = 2 * H + HB;
    localparam int K    = (VS + VB + V + VF) * LINE;

    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    localparam logic [7:0] LINE0 [32] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'hFF, 8'hE0,
                                          8'h07, 8'hFF, 8'h07, 8'hFF, 8'h07, 8'hE0, 8'h07, 8'hE0,
                                          8'hF8, 8'h1F, 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'hF8, 8'h00,
                                          8'h00, 8'h1F, 8'h00, 8'h1F, 8'h00, 8'h00, 8'h00, 8'h00};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] solid = 16'h0000;
    logic        pclk_o, vsync_o, href_o, frame_done_o;
    logic [7:0]  d_o;
    logic [15:0] frame_count_o, frame_crc_o;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ov7670_stream_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .VSYNC_LINES(VS),
        .V_BACK(VB), .V_FRONT(VF), .SQ_SIZE(SQ), .SQ_STEP(STP)
    ) dut (
        .clk_i(clk), .reset_i(reset), .en_i(en), .mode_i(mode), .solid_rgb_i(solid),
        .pclk_o(pclk_o), .vsync_o(vsync_o), .href_o(href_o), .d_o(d_o),
        .frame_done_o(frame_done_o), .frame_count_o(frame_count_o), .frame_crc_o(frame_crc_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_pix(int m, int x, int y, int sq, logic [15:0] sol);
        int yc;
        yc = V / 2 - SQ / 2;
        case (m)
            0: return BARS[x * 8 / H];
            1: return 16'(((x >> 3) << 11) | ((x >> 2) << 5) | (x >> 3));
            2: return sol;
            default: return (x >= sq && x < sq + SQ && y >= yc && y < yc + SQ) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] ref_crc(logic [15:0] c, logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ b[i]) r = 16'((r << 1) ^ 16'h1021);
            else              r = 16'(r << 1);
        end
        return r;
    endfunction

    // Reference model: expected outputs after each rising edge
    bit          m_active = 0;
    int          m_t = 0;
    int          m_mode = 0;
    logic [15:0] m_solid = 0;
    int          m_sq = 0;
    logic [15:0] m_crc = 16'hFFFF;
    logic        e_pclk = 0, e_vsync = 0, e_href = 0, e_done = 0;
    logic [7:0]  e_d = 0;
    logic [15:0] e_cnt = 0, e_crc = 0;

    always @(posedge clk) begin
        int k, l, h, row;
        logic [15:0] px;
        if (reset) begin
            m_active = 0; m_t = 0; m_sq = 0;
            e_pclk = 0; e_vsync = 0; e_href = 0; e_d = 0; e_done = 0; e_cnt = 0; e_crc = 0;
        end else begin
            e_done = 0;
            if (!m_active) begin
                e_pclk = 0;
                if (en) begin
                    m_active = 1; m_t = 0; m_mode = int'(mode); m_solid = solid; m_crc = 16'hFFFF;
                end
            end else begin
                m_t++;
                e_pclk = (m_t % 2) == 1;
                if (m_t % 2 == 0) begin
                    k = m_t / 2 - 1;
                    l = k / LINE;
                    h = k % LINE;
                    row = l - VS - VB;
                    e_vsync = (l < VS);
                    e_href = (row >= 0) && (row < V) && (h < 2 * H);
                    if (e_href) begin
                        px = ref_pix(m_mode, h / 2, row, m_sq, m_solid);
                        e_d = (h % 2 == 0) ? px[15:8] : px[7:0];
                        m_crc = ref_crc(m_crc, e_d);
                    end else begin
                        e_d = 0;
                    end
                    if (k == K - 1) begin
                        e_done = 1;
                        e_cnt = e_cnt + 16'd1;
`ifdef STREAM_GEN_CRC_EN
                        e_crc = m_crc;
`endif
                        m_sq = (m_sq + STP + SQ > H) ? 0 : m_sq + STP;
                        if (en) begin
                            m_t = 0; m_mode = int'(mode); m_solid = solid; m_crc = 16'hFFFF;
                        end else begin
                            m_active = 0;
                        end
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("pclk", 32'(pclk_o), 32'(e_pclk));
            check("vsync", 32'(vsync_o), 32'(e_vsync));
            check("href", 32'(href_o), 32'(e_href));
            check("d", 32'(d_o), 32'(e_d));
            check("frame_done", 32'(frame_done_o), 32'(e_done));
            check("frame_count", 32'(frame_count_o), 32'(e_cnt));
            check("frame_crc", 32'(frame_crc_o), 32'(e_crc));
        end
    end

    // Byte capture and per-frame line count
    logic [7:0] cap [128];
    int  nbyte = 0;
    int  lines = 0;
    bit  href_prev = 0;
    always @(negedge clk) begin
        if (vsync_o) begin nbyte = 0; lines = 0; end
        if (pclk_o && href_o) begin
            if (nbyte < 128) cap[nbyte] = d_o;
            nbyte++;
        end
        if (href_o && !href_prev) lines++;
        href_prev = href_o;
        if (frame_done_o && chk_en) check("lines_per_frame", 32'(lines), 32'(V));
    end

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done_o && n < 4000);
        check("done_timeout", 32'(frame_done_o), 32'd1);
    endtask

    task automatic wait_href();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!href_o && n < 4000);
        check("href_timeout", 32'(href_o), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, vs, hr, rises, done_at;
        bit prev;
        bit got_sq, exp_sq;

        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset with en low
        repeat (10) begin
            @(negedge clk);
            check("idle_pclk", 32'(pclk_o), 32'd0);
            check("idle_done", 32'(frame_done_o), 32'd0);
            check("idle_count", 32'(frame_count_o), 32'd0);
        end

        // First frame, colour bars: timing measured directly
        mode = 2'd0;
        en = 1'b1;
        n = 0; vs = 0; hr = 0; rises = 0; done_at = 0; prev = 0;
        while (n < 2000 && done_at == 0) begin
            @(negedge clk);
            n++;
            if (vsync_o) vs++;
            if (href_o) hr++;
            if (href_o && !prev) rises++;
            prev = href_o;
            if (frame_done_o) done_at = n;
        end
        check("done_latency", 32'(done_at), 32'd505);
        check("vsync_clks", 32'(vs), 32'd72);
        check("href_clks", 32'(hr), 32'd256);
        check("href_pulses", 32'(rises), 32'd4);
        check("count_after_1", 32'(frame_count_o), 32'd1);
        for (int i = 0; i < 32; i++) check("bars_line0", 32'(cap[i]), 32'(LINE0[i]));

        // Frame 2: change mode and drop en mid-ACTIVE
        wait_href();
        repeat (10) @(negedge clk);
        mode = 2'd1;
        en = 1'b0;
        wait_done();
        check("count_after_2", 32'(frame_count_o), 32'd2);
        repeat (20) begin
            @(negedge clk);
            check("stopped_pclk", 32'(pclk_o), 32'd0);
        end

        // Randomised modes, colours and en toggling
        for (int r = 0; r < 8; r++) begin
            mode = 2'($urandom_range(0, 2));
            solid = 16'($urandom);
            en = 1'b1;
            repeat ($urandom_range(1, 700)) @(negedge clk);
            mode = 2'($urandom_range(0, 3));
            solid = 16'($urandom);
            en = 1'($urandom_range(0, 1));
            if (!en) repeat (600) @(negedge clk);
        end
        en = 1'b0;
        repeat (600) @(negedge clk);

        // Moving square from a fresh reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mode = 2'd3;
        en = 1'b1;
        for (int f = 0; f < 16; f++) begin
            wait_done();
            exp_sq = (f % 7 == 2) || (f % 7 == 3);
            got_sq = (cap[44] == 8'hFF) && (cap[45] == 8'hFF);
            check("square_x6_y1", 32'(got_sq), 32'(exp_sq));
            exp_sq = (f % 7 == 0);
            got_sq = (cap[32] == 8'hFF) && (cap[33] == 8'hFF);
            check("square_x0_y1", 32'(got_sq), 32'(exp_sq));
        end

        // Reset in the middle of an active line
        wait_href();
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_href", 32'(href_o), 32'd0);
        check("rst_vsync", 32'(vsync_o), 32'd0);
        check("rst_d", 32'(d_o), 32'd0);
        check("rst_count", 32'(frame_count_o), 32'd0);
        check("rst_pclk", 32'(pclk_o), 32'd0);
        reset = 1'b0;

        // Solid black frame: CRC over all-zero active bytes
        mode = 2'd2;
        solid = 16'h0000;
        en = 1'b1;
        wait_done();
        en = 1'b0;
        check("crc_zero_frame", 32'(frame_crc_o), 32'(e_crc));
        repeat (600) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
